// File: rtl/reg_file_pkg.sv
// Shared CPU definitions: default register file geometry and scan engine state encoding.
package cpu_defs;

  localparam int DFLT_DATA_W = 32;
  localparam int DFLT_ADDR_W = 5;
  localparam int REG_ZERO    = 0;

  typedef enum logic {
    SCAN_IDLE = 1'b0,
    SCAN_RUN  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/reg_file_if.sv
// Register file bus: two read ports, one write port and the debug scan stream.
interface reg_file_if
  import cpu_defs::*;
#(
  parameter int DATA_W = DFLT_DATA_W,
  parameter int ADDR_W = DFLT_ADDR_W
);

  logic [ADDR_W-1:0] rd_addr_a;
  logic [DATA_W-1:0] rd_data_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_b;
  logic              we;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              dbg_start;
  logic              dbg_ready;
  logic              dbg_valid;
  logic [ADDR_W-1:0] dbg_idx;
  logic [DATA_W-1:0] dbg_data;
  logic              dbg_last;
  logic              dbg_busy;

  modport master (
    output rd_addr_a, rd_addr_b, we, wr_addr, wr_data, dbg_start, dbg_ready,
    input  rd_data_a, rd_data_b, dbg_valid, dbg_idx, dbg_data, dbg_last, dbg_busy
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, we, wr_addr, wr_data, dbg_start, dbg_ready,
    output rd_data_a, rd_data_b, dbg_valid, dbg_idx, dbg_data, dbg_last, dbg_busy
  );

endinterface

// File: rtl/reg_file_scan.sv
// Debug scan engine: streams every register out one beat per valid/ready handshake.
// First beat appears the cycle after start; holds idx/data while ready is low.
module reg_file_scan
  import cpu_defs::*;
#(
  parameter int DATA_W = DFLT_DATA_W,
  parameter int ADDR_W = DFLT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ready,
  output logic [ADDR_W-1:0] rd_idx,
  input  logic [DATA_W-1:0] rd_data,
  output logic              valid,
  output logic [ADDR_W-1:0] idx,
  output logic [DATA_W-1:0] data,
  output logic              last,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  scan_state_t state;

  // Look one register ahead so the next beat's data is captured at the advance edge.
  assign rd_idx = idx + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SCAN_IDLE;
      valid <= 1'b0;
      idx   <= '0;
      data  <= '0;
    end else begin
      case (state)
        SCAN_IDLE: begin
          if (start) begin
            state <= SCAN_RUN;
            valid <= 1'b1;
            idx   <= '0;
            data  <= '0;
          end
        end
        SCAN_RUN: begin
          if (valid && ready) begin
            if (idx == LAST_IDX) begin
              state <= SCAN_IDLE;
              valid <= 1'b0;
            end else begin
              idx  <= rd_idx;
              data <= rd_data;
            end
          end
        end
      endcase
    end
  end

  assign last = valid && (idx == LAST_IDX);
  assign busy = (state == SCAN_RUN);

endmodule

// File: rtl/reg_file.sv
// Integer register file: two combinational read ports with optional write bypass,
// one synchronous write port, register 0 hardwired to zero, plus a debug scan engine.
module reg_file
  import cpu_defs::*;
#(
  parameter int DATA_W = DFLT_DATA_W,
  parameter int ADDR_W = DFLT_ADDR_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  reg_file_if.slave bus
);

  localparam int                NREGS     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs [NREGS];
  logic [ADDR_W-1:0] scan_rd_idx;
  logic [DATA_W-1:0] scan_rd_data;
  logic              wr_live;

  assign wr_live = bus.we && (bus.wr_addr != ZERO_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_live) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Address 0 wins over bypass, so a discarded write to r0 never leaks onto a read port.
  assign bus.rd_data_a = (bus.rd_addr_a == ZERO_ADDR) ? '0 :
                         (BYPASS && bus.we && (bus.wr_addr == bus.rd_addr_a)) ? bus.wr_data :
                         regs[bus.rd_addr_a];

  assign bus.rd_data_b = (bus.rd_addr_b == ZERO_ADDR) ? '0 :
                         (BYPASS && bus.we && (bus.wr_addr == bus.rd_addr_b)) ? bus.wr_data :
                         regs[bus.rd_addr_b];

  // The scan sees the raw array: a write landing at the same edge is not in the beat.
  assign scan_rd_data = regs[scan_rd_idx];

  reg_file_scan #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_scan (
    .clk     (clk),
    .rst     (rst),
    .start   (bus.dbg_start),
    .ready   (bus.dbg_ready),
    .rd_idx  (scan_rd_idx),
    .rd_data (scan_rd_data),
    .valid   (bus.dbg_valid),
    .idx     (bus.dbg_idx),
    .data    (bus.dbg_data),
    .last    (bus.dbg_last),
    .busy    (bus.dbg_busy)
  );

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: table-driven read/write vectors plus a scoreboard-checked scan stream.
module tb_reg_file;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic clk;
  logic rst;

  reg_file_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  bit          chk_rd = 1'b0;
  bit          chk_scan = 1'b0;
  logic [31:0] exp_a;
  logic [31:0] exp_b;
  logic [31:0] model [32];
  bit          m_valid = 1'b0;
  int          m_idx = 0;
  beat_t       sb_q [$];
  vec_t        vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: compare at the falling edge, advance the reference model, then cross the rising edge.
  task automatic tick();
    beat_t b;
    @(negedge clk);
    if (chk_rd) begin
      check("rd_data_a", 64'(bus.rd_data_a), 64'(exp_a));
      check("rd_data_b", 64'(bus.rd_data_b), 64'(exp_b));
    end
    if (chk_scan) begin
      check("dbg_valid", 64'(bus.dbg_valid), 64'(m_valid));
      check("dbg_busy", 64'(bus.dbg_busy), 64'(m_valid));
      if (m_valid && sb_q.size() > 0) begin
        b = sb_q[0];
        check("dbg_idx", 64'(bus.dbg_idx), 64'(b.idx));
        check("dbg_data", 64'(bus.dbg_data), 64'(b.data));
        check("dbg_last", 64'(bus.dbg_last), 64'(b.last));
        if (bus.dbg_ready) void'(sb_q.pop_front());
      end else if (!m_valid) begin
        check("dbg_last_idle", 64'(bus.dbg_last), 64'(0));
      end
    end
    if (rst) begin
      m_valid = 1'b0;
      sb_q.delete();
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else begin
      if (m_valid) begin
        if (bus.dbg_ready) begin
          if (m_idx == 31) begin
            m_valid = 1'b0;
          end else begin
            m_idx++;
            sb_q.push_back(beat_t'{idx: 5'(m_idx), data: model[m_idx], last: (m_idx == 31)});
          end
        end
      end else if (bus.dbg_start) begin
        m_valid = 1'b1;
        m_idx = 0;
        sb_q.push_back(beat_t'{idx: 5'd0, data: 32'h0, last: 1'b0});
      end
      if (bus.we && bus.wr_addr != 5'd0) model[bus.wr_addr] = bus.wr_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_idle(input int bound);
    for (int k = 0; k < bound && m_valid; k++) tick();
    if (m_valid) begin
      n_cmp++;
      n_err++;
      $display("FAIL scan_timeout: still scanning at idx %0d after %0d cycles", m_idx, bound);
    end
    tick();
  endtask

  task automatic run_until_idx(input int target, input int bound);
    for (int k = 0; k < bound && !(m_valid && m_idx == target); k++) tick();
    if (!(m_valid && m_idx == target)) begin
      n_cmp++;
      n_err++;
      $display("FAIL scan_reach_idx: wanted %0d got %0d", target, m_idx);
    end
  endtask

  task automatic read_all_zero();
    chk_rd = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.rd_addr_a = 5'(i);
      bus.rd_addr_b = 5'(31 - i);
      exp_a = 32'h0;
      exp_b = 32'h0;
      tick();
    end
    chk_rd = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd5,  32'h01234567, 5'd0,  5'd5,  32'h00000000, 32'h01234567};
    vecs[1] = '{1'b0, 5'd0,  32'h00000000, 5'd5,  5'd0,  32'h01234567, 32'h00000000};
    vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h00000000, 32'h00000000};
    vecs[3] = '{1'b0, 5'd0,  32'h00000000, 5'd0,  5'd5,  32'h00000000, 32'h01234567};
    vecs[4] = '{1'b1, 5'd9,  32'hDEADBEEF, 5'd9,  5'd5,  32'hDEADBEEF, 32'h01234567};
    vecs[5] = '{1'b1, 5'd9,  32'hCAFEF00D, 5'd9,  5'd9,  32'hCAFEF00D, 32'hCAFEF00D};
    vecs[6] = '{1'b0, 5'd0,  32'h00000000, 5'd9,  5'd9,  32'hCAFEF00D, 32'hCAFEF00D};
    vecs[7] = '{1'b1, 5'd5,  32'h00000000, 5'd9,  5'd5,  32'hCAFEF00D, 32'h00000000};
    vecs[8] = '{1'b0, 5'd0,  32'h00000000, 5'd5,  5'd9,  32'h00000000, 32'hCAFEF00D};
    vecs[9] = '{1'b1, 5'd31, 32'h80000001, 5'd31, 5'd30, 32'h80000001, 32'h00000000};

    rst = 1'b1;
    bus.rd_addr_a = '0;
    bus.rd_addr_b = '0;
    bus.we = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.dbg_start = 1'b0;
    bus.dbg_ready = 1'b0;
    exp_a = '0;
    exp_b = '0;
    repeat (3) tick();
    rst = 1'b0;

    check("rst_dbg_valid", 64'(bus.dbg_valid), 64'(0));
    check("rst_dbg_idx", 64'(bus.dbg_idx), 64'(0));
    check("rst_dbg_data", 64'(bus.dbg_data), 64'(0));
    check("rst_dbg_last", 64'(bus.dbg_last), 64'(0));
    check("rst_dbg_busy", 64'(bus.dbg_busy), 64'(0));
    chk_scan = 1'b1;
    read_all_zero();

    chk_rd = 1'b1;
    for (int v = 0; v < 10; v++) begin
      bus.we = vecs[v].we;
      bus.wr_addr = vecs[v].wa;
      bus.wr_data = vecs[v].wd;
      bus.rd_addr_a = vecs[v].ra;
      bus.rd_addr_b = vecs[v].rb;
      exp_a = vecs[v].ea;
      exp_b = vecs[v].eb;
      tick();
    end
    bus.we = 1'b0;
    chk_rd = 1'b0;

    // Full scan of a patterned file; start held high into SCAN must be ignored.
    for (int n = 1; n < 32; n++) begin
      bus.we = 1'b1;
      bus.wr_addr = 5'(n);
      bus.wr_data = 32'(n) * 32'h11111111;
      tick();
    end
    bus.we = 1'b0;
    bus.dbg_ready = 1'b1;
    bus.dbg_start = 1'b1;
    repeat (3) tick();
    bus.dbg_start = 1'b0;
    run_until_idle(100);

    // Stall at idx 7 while rewriting r7 and r8.
    bus.dbg_start = 1'b1;
    tick();
    bus.dbg_start = 1'b0;
    run_until_idx(7, 50);
    bus.dbg_ready = 1'b0;
    bus.we = 1'b1;
    bus.wr_addr = 5'd7;
    bus.wr_data = 32'hA5A5A5A5;
    tick();
    bus.wr_addr = 5'd8;
    bus.wr_data = 32'h5A5A5A5A;
    tick();
    bus.we = 1'b0;
    tick();
    bus.dbg_ready = 1'b1;
    run_until_idle(100);

    // Reset mid-scan at idx 12, colliding with a write and a start request.
    bus.dbg_start = 1'b1;
    tick();
    bus.dbg_start = 1'b0;
    run_until_idx(12, 50);
    rst = 1'b1;
    bus.we = 1'b1;
    bus.wr_addr = 5'd3;
    bus.wr_data = 32'hFFFFFFFF;
    bus.dbg_start = 1'b1;
    tick();
    rst = 1'b0;
    bus.we = 1'b0;
    bus.dbg_start = 1'b0;
    tick();
    read_all_zero();
    bus.dbg_start = 1'b1;
    tick();
    bus.dbg_start = 1'b0;
    run_until_idle(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
